// File: rtl/bp_fe_queue_fifo.sv
// FE-to-BE instruction queue with speculative read, roll (replay) and commit pointers.
// Define BP_FE_QUEUE_BYPASS_EN to present an enqueued packet in the same cycle when the queue is empty.
module bp_fe_queue_fifo #(
    parameter int els_p         = 8,
    parameter int entry_width_p = 128
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [entry_width_p-1:0]     fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [entry_width_p-1:0]     fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_yumi_i,
    input  logic                         fe_queue_clr_i,
    input  logic                         fe_queue_roll_i,
    input  logic                         fe_queue_deq_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int addr_w_lp = $clog2(els_p);
    localparam int ptr_w_lp  = addr_w_lp + 1;
    localparam int cnt_w_lp  = $clog2(els_p + 1);

    logic [entry_width_p-1:0] mem_q [els_p];

    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] cptr_q, cptr_d;
    logic [ptr_w_lp-1:0] occupancy;

    logic full;
    logic empty;
    logic enq;
    logic wr_en;
    logic yumi_eff;

    assign occupancy = wptr_q - cptr_q;
    assign full      = (occupancy == ptr_w_lp'(els_p));
    assign empty     = (rptr_q == wptr_q);
    assign enq       = fe_queue_v_i & ~full;
    assign wr_en     = enq & ~fe_queue_clr_i;
    assign yumi_eff  = fe_queue_yumi_i & ~fe_queue_roll_i;

    assign fe_queue_ready_o = ~full;
    assign count_o          = cnt_w_lp'(occupancy);

`ifdef BP_FE_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming packet; it is still written so a roll can replay it.
    assign fe_queue_v_o = ~empty | (enq & ~fe_queue_clr_i);
    assign fe_queue_o   = empty ? fe_queue_i : mem_q[rptr_q[addr_w_lp-1:0]];
`else
    assign fe_queue_v_o = ~empty;
    assign fe_queue_o   = mem_q[rptr_q[addr_w_lp-1:0]];
`endif

    // Resolution order: deq, roll, yumi, clr, enqueue.
    always_comb begin
        cptr_d = cptr_q + ptr_w_lp'(fe_queue_deq_i);
        if (fe_queue_roll_i) begin
            rptr_d = cptr_d;
        end else begin
            rptr_d = rptr_q + ptr_w_lp'(yumi_eff);
        end
        if (fe_queue_clr_i) begin
            wptr_d = rptr_d;
        end else begin
            wptr_d = wptr_q + ptr_w_lp'(enq);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q[addr_w_lp-1:0]] <= fe_queue_i;
        end
    end

    yumi_needs_valid_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) fe_queue_yumi_i |-> fe_queue_v_o);

    deq_needs_read_entry_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) fe_queue_deq_i |-> (cptr_q != rptr_q));

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// Self-checking bench for bp_fe_queue_fifo: directed test-plan steps followed by a random phase,
// checked against a queue-of-packets model (uncommitted list plus read offset).
module tb_bp_fe_queue_fifo;

    localparam int ELS = 4;
    localparam int W   = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  fe_queue_i = '0;
    logic          fe_queue_v_i = 1'b0;
    logic          fe_queue_ready_o;
    logic [W-1:0]  fe_queue_o;
    logic          fe_queue_v_o;
    logic          fe_queue_yumi_i = 1'b0;
    logic          fe_queue_clr_i = 1'b0;
    logic          fe_queue_roll_i = 1'b0;
    logic          fe_queue_deq_i = 1'b0;
    logic [$clog2(ELS+1)-1:0] count_o;

    always #5 clk = ~clk;

    bp_fe_queue_fifo #(.els_p(ELS), .entry_width_p(W)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .fe_queue_i       (fe_queue_i),
        .fe_queue_v_i     (fe_queue_v_i),
        .fe_queue_ready_o (fe_queue_ready_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_yumi_i  (fe_queue_yumi_i),
        .fe_queue_clr_i   (fe_queue_clr_i),
        .fe_queue_roll_i  (fe_queue_roll_i),
        .fe_queue_deq_i   (fe_queue_deq_i),
        .count_o          (count_o)
    );

    // Model: mq holds every uncommitted packet oldest first; rd_off of them have been read.
    logic [W-1:0] mq [$];
    int           rd_off = 0;
    int           n_checks = 0;
    int           n_err = 0;
`ifdef BP_FE_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_valid(input bit v, input bit clr);
        return (rd_off < mq.size()) || (BYPASS && v && (mq.size() < ELS) && !clr);
    endfunction

    task automatic check_outputs(input string tag);
        bit exp_v;
        exp_v = model_valid(fe_queue_v_i, fe_queue_clr_i);
        chk({tag, ".ready"}, 32'(fe_queue_ready_o), 32'(mq.size() < ELS));
        chk({tag, ".valid"}, 32'(fe_queue_v_o), 32'(exp_v));
        chk({tag, ".count"}, 32'(count_o), 32'(mq.size()));
        if (exp_v)
            chk({tag, ".data"}, 32'(fe_queue_o),
                32'((rd_off < mq.size()) ? mq[rd_off] : fe_queue_i));
    endtask

    task automatic step(input string tag, input bit v, input logic [W-1:0] d,
                        input bit yumi, input bit clr, input bit roll, input bit deq);
        bit enq;
        @(negedge clk);
        fe_queue_v_i    = v;
        fe_queue_i      = d;
        fe_queue_yumi_i = yumi;
        fe_queue_clr_i  = clr;
        fe_queue_roll_i = roll;
        fe_queue_deq_i  = deq;
        #1;
        check_outputs(tag);
        enq = v && (mq.size() < ELS);
        @(posedge clk);
        if (deq) begin
            void'(mq.pop_front());
            rd_off--;
        end
        if (roll) rd_off = 0;
        else if (yumi) rd_off++;
        if (clr) begin
            while (mq.size() > rd_off) void'(mq.pop_back());
        end else if (enq) begin
            mq.push_back(d);
        end
        #1;
        fe_queue_v_i    = 1'b0;
        fe_queue_yumi_i = 1'b0;
        fe_queue_clr_i  = 1'b0;
        fe_queue_roll_i = 1'b0;
        fe_queue_deq_i  = 1'b0;
        $display("step %-8s v=%0b d=%04h yumi=%0b clr=%0b roll=%0b deq=%0b -> count=%0d rd_off=%0d",
                 tag, v, d, yumi, clr, roll, deq, mq.size(), rd_off);
    endtask

    task automatic drain(input string tag);
        while (rd_off < mq.size()) step(tag, 0, '0, 1, 0, 0, 0);
        while (mq.size() > 0) step(tag, 0, '0, 0, 0, 0, 1);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst.valid", 32'(fe_queue_v_o), 32'd0);
        chk("rst.ready", 32'(fe_queue_ready_o), 32'd1);
        chk("rst.count", 32'(count_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, read all, first deq reopens the queue
        for (int i = 0; i < 4; i++) step("fill", 1, 16'hA0 + 16'(i), 0, 0, 0, 0);
        chk("fill.count4", 32'(count_o), 32'd4);
        chk("fill.notready", 32'(fe_queue_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) step("rdall", 0, '0, 1, 0, 0, 0);
        chk("rdall.notready", 32'(fe_queue_ready_o), 32'd0);
        step("deq1", 0, '0, 0, 0, 0, 1);
        chk("deq1.ready", 32'(fe_queue_ready_o), 32'd1);
        drain("drain1");

        // Roll replays A,B then C
        for (int i = 0; i < 3; i++) step("enq", 1, 16'hB0 + 16'(i), 0, 0, 0, 0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        step("roll", 0, '0, 0, 0, 1, 0);
        chk("roll.dataA", 32'(fe_queue_o), 32'h00B0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        chk("roll.dataB", 32'(fe_queue_o), 32'h00B1);
        step("yumi", 0, '0, 1, 0, 0, 0);
        chk("roll.dataC", 32'(fe_queue_o), 32'h00B2);
        chk("roll.count3", 32'(count_o), 32'd3);
        drain("drain2");

        // Yumi with clr drops unread entries
        for (int i = 0; i < 3; i++) step("enq", 1, 16'hC0 + 16'(i), 0, 0, 0, 0);
        step("yumiclr", 0, '0, 1, 1, 0, 0);
        chk("clr.valid", 32'(fe_queue_v_o), 32'd0);
        chk("clr.count1", 32'(count_o), 32'd1);
        step("deq", 0, '0, 0, 0, 0, 1);
        chk("clr.count0", 32'(count_o), 32'd0);

        // Deq together with roll
        step("enq", 1, 16'hD0, 0, 0, 0, 0);
        step("enq", 1, 16'hD1, 0, 0, 0, 0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        step("deqroll", 0, '0, 0, 0, 1, 1);
        chk("deqroll.data", 32'(fe_queue_o), 32'h00D1);
        chk("deqroll.count", 32'(count_o), 32'd1);
        drain("drain3");

        // Clr together with roll discards everything uncommitted
        for (int i = 0; i < 3; i++) step("enq", 1, 16'hE0 + 16'(i), 0, 0, 0, 0);
        step("yumi", 0, '0, 1, 0, 0, 0);
        step("clrroll", 0, '0, 0, 1, 1, 0);
        chk("clrroll.count", 32'(count_o), 32'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) step("enq", 1, 16'hF0 + 16'(i), 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.valid", 32'(fe_queue_v_o), 32'd0);
        chk("arst.count", 32'(count_o), 32'd0);
        chk("arst.ready", 32'(fe_queue_ready_o), 32'd1);
        mq.delete();
        rd_off = 0;
        @(negedge clk);
        reset_n = 1'b1;
        step("postrst", 0, '0, 0, 0, 0, 0);
        chk("postrst.valid", 32'(fe_queue_v_o), 32'd0);

        if (BYPASS) begin
            step("bypass", 1, 16'h5A5A, 1, 0, 0, 0);
            step("bproll", 0, '0, 0, 0, 1, 0);
            chk("bypass.replay", 32'(fe_queue_o), 32'h5A5A);
            drain("drain4");
        end

        // Random phase with legal control combinations
        for (int n = 0; n < 600; n++) begin
            bit v, clr, roll, yumi, deq;
            v    = ($urandom % 3) != 0;
            clr  = ($urandom % 12) == 0;
            roll = ($urandom % 10) == 0;
            deq  = (rd_off > 0) && (($urandom % 3) == 0);
            yumi = model_valid(v, clr) && (($urandom % 2) == 0);
            step("rand", v, 16'($urandom), yumi, clr, roll, deq);
        end
        drain("drainR");
        chk("final.count", 32'(count_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bp_fe_queue_fifo.md
Name: bp_fe_queue_fifo

Overview:
Producer-side FE-to-BE instruction queue. It buffers fetch/exception packets from the front end and presents them to the back-end scheduler with a valid/yumi handshake. It supports the scheduler's speculative-read controls: clear, roll and dequeue. It keeps entries that have been read but not committed, so that a roll (cache-miss replay) can re-present them.

Parameters:
els_p, 8, queue depth; power of two, at least 2
entry_width_p, 128, width of one FE queue packet (fe_queue_width_lp at instantiation)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fe_queue_i  in  entry_width_p  packet from FE
fe_queue_v_i  in  1  FE packet valid
fe_queue_ready_o  out  1  queue can accept a packet this cycle
fe_queue_o  out  entry_width_p  packet at the read pointer
fe_queue_v_o  out  1  fe_queue_o valid
fe_queue_yumi_i  in  1  BE consumes fe_queue_o (speculative read)
fe_queue_clr_i  in  1  discard all unread entries
fe_queue_roll_i  in  1  rewind the read pointer to the commit pointer
fe_queue_deq_i  in  1  commit the oldest read entry
count_o  out  $clog2(els_p+1)  uncommitted occupancy (wptr - cptr)

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset is asynchronous and active-low on reset_n_i.
- State: storage array of els_p entries (not reset). Three pointers, each $clog2(els_p)+1 bits wide including a wrap bit:
  - wptr: write pointer
  - rptr: speculative read pointer
  - cptr: commit pointer
- Invariant: cptr <= rptr <= wptr (modular). All pointer arithmetic wraps at 2*els_p.
- Reset: wptr = rptr = cptr = 0; fe_queue_v_o = 0; fe_queue_ready_o = 1; count_o = 0. Takes effect immediately on reset_n_i fall.
- Full: wptr - cptr == els_p. fe_queue_ready_o = ~full. Committed-pending entries are never overwritten.
- Empty for read: rptr == wptr. fe_queue_v_o = ~empty; fe_queue_o = mem[rptr low bits]. No bypass: a packet becomes visible 1 cycle after it is enqueued.
- Enqueue: fe_queue_v_i & fe_queue_ready_o writes mem[wptr] and increments wptr.
- Yumi: rptr increments. Yumi without fe_queue_v_o is illegal and is assertion-checked.
- Deq: cptr increments. Deq with cptr == rptr is illegal and is assertion-checked.
- Roll: rptr <= cptr. Entries between cptr and rptr are re-presented in their original order.
  - Any yumi in the same cycle is ignored.
  - Deq in the same cycle is applied first, i.e. rptr <= cptr+1.
- Clr: wptr <= rptr_next, where rptr_next includes a same-cycle yumi. All unread entries are dropped.
  - Enqueue in the same cycle is dropped.
  - fe_queue_ready_o does not depend on clr.
- Clr together with roll: rptr <= cptr_next and wptr <= cptr_next. Every uncommitted entry is discarded.
- Resolution order within a cycle: deq, then roll, then yumi, then clr, then enqueue.
- count_o = wptr - cptr, registered-pointer based, zero-extended.

Optional Feature:
BP_FE_QUEUE_BYPASS_EN
- Defined:
  - When rptr == wptr and fe_queue_v_i & fe_queue_ready_o, fe_queue_v_o = 1 and fe_queue_o = fe_queue_i combinationally.
  - A same-cycle yumi still writes the entry to mem[wptr] and advances both wptr and rptr, so the entry remains available for roll.
  - clr in a bypass cycle suppresses fe_queue_v_o.
- Undefined: 1-cycle enqueue-to-valid latency as described in Behaviour.

Test Plan:
- els_p=4. Enqueue A,B,C,D back-to-back -> ready_o=0 after D, count_o=4. Yumi all four -> ready_o stays 0 until the first deq, then 1 the next cycle.
- Enqueue A,B,C; yumi A,B; roll -> fe_queue_o=A next cycle, then B, then C; count_o stays 3.
- Enqueue A,B,C; yumi A with clr in the same cycle -> wptr=rptr=1, fe_queue_v_o=0. Deq -> count_o=0.
- Enqueue A,B; yumi A,B; deq A together with roll -> next fe_queue_o=B, count_o=1.
- Assert reset_n_i mid-stream with 3 entries -> fe_queue_v_o=0, count_o=0, ready_o=1 immediately; no stale packet after release.
- With BYPASS_EN and the queue empty: fe_queue_v_i=1 with X, yumi in the same cycle -> fe_queue_o=X that cycle. Roll next cycle -> X re-presented.
